// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit: next-PC select
// encodings (as driven by the control unit), FSM state encodings and a
// helper that builds the beq byte offset.
//
// Optional feature macro: IFU_ALIGN_CHECK_EN adds the ERR state.
// ----------------------------------------------------------------------------
package ifu_pkg;

    // Next-PC select values from the control unit
    localparam logic [1:0] NPC_PLUS4 = 2'b00;
    localparam logic [1:0] NPC_BEQ   = 2'b01;
    localparam logic [1:0] NPC_JUMP  = 2'b10;
    localparam logic [1:0] NPC_JR    = 2'b11;

    // Fetch FSM states; ERR exists only when alignment checking is built in
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01
`ifdef IFU_ALIGN_CHECK_EN
        ,
        ERR   = 2'b10
`endif
    } ifu_state_t;

    // Sign-extended word offset of a branch, already scaled to bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// ----------------------------------------------------------------------------
// npc
// Purely combinational next-PC computation for the single-cycle MIPS core.
//
// Ports:
//   pc       in  32  address of the current instruction
//   instr    in  32  current instruction word (imm16 / jump target fields)
//   s        in  2   next-PC select (PLUS4 / BEQ / JUMP / JR)
//   zero     in  1   ALU zero flag, beq is taken when set
//   rs_data  in  32  register rs value, jr target
//   next_pc  out 32  computed next PC (wraps modulo 2^32)
// ----------------------------------------------------------------------------
module npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  s,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc
);

    logic [31:0] seq_pc;
    logic        unused_opcode;

    // The opcode field does not take part in the target computation
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        seq_pc  = pc + 32'd4;
        next_pc = seq_pc;
        case (s)
            NPC_PLUS4: next_pc = seq_pc;
            NPC_BEQ:   next_pc = zero ? seq_pc + branch_offset(instr[15:0]) : seq_pc;
            // Jump region comes from the sequential PC, not the jump's own PC
            NPC_JUMP:  next_pc = {seq_pc[31:28], instr[25:0], 2'b00};
            NPC_JR:    next_pc = rs_data;
            default:   next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu
// Instruction fetch unit. Holds the PC, fetches from instruction memory over
// a req/ack handshake, holds the fetched word for decode and advances the PC
// when the datapath retires the instruction.
//
// Parameters:
//   RESET_PC      PC loaded on reset (default 32'h0000_3000)
//
// Ports:
//   clk           in  1   clock, rising edge
//   rst_n         in  1   synchronous active-low reset
//   imem_req      out 1   fetch request (forced low while rst_n is low)
//   imem_addr     out 32  fetch byte address (= pc)
//   imem_ack      in  1   imem_rdata valid this cycle
//   imem_rdata    in  32  fetched instruction word
//   instr         out 32  held instruction
//   instr_valid   out 1   instr valid and awaiting retire
//   pc            out 32  address of the current instruction
//   pc_plus4      out 32  pc + 4 (jal link value)
//   retire        in  1   current instruction finished, next-PC inputs valid
//   s             in  2   next-PC select
//   zero          in  1   ALU zero flag
//   rs_data       in  32  jr target
//   retired_cnt   out 32  retired instruction count (wraps)
//   addr_err      out 1   misaligned next PC seen (sticky)
//
// Optional feature macro: IFU_ALIGN_CHECK_EN. When undefined there is no
// ERR state, addr_err is tied low and the next PC is loaded unchanged.
// ----------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic [1:0]  s,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] retired_cnt,
    output logic        addr_err
);

    ifu_state_t  state;
    ifu_state_t  state_nxt;
    logic [31:0] next_pc;
    logic        load_instr;
    logic        count_retire;
    logic        update_pc;

    npc u_npc (
        .pc      (pc),
        .instr   (instr),
        .s       (s),
        .zero    (zero),
        .rs_data (rs_data),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Ack is only honoured in FETCH and retire only in HOLD; anything else
    // is ignored by construction of this case.
    always_comb begin
        state_nxt    = state;
        load_instr   = 1'b0;
        count_retire = 1'b0;
        update_pc    = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    count_retire = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
                    // A misaligned target still retires the instruction but
                    // the PC is frozen and the unit parks until reset.
                    if (next_pc[1:0] != 2'b00) begin
                        state_nxt = ERR;
                    end else begin
                        update_pc = 1'b1;
                        state_nxt = FETCH;
                    end
`else
                    update_pc = 1'b1;
                    state_nxt = FETCH;
`endif
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            ERR: begin
                state_nxt = ERR;
            end
`endif
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            retired_cnt <= 32'd0;
        end else begin
            if (load_instr) begin
                instr <= imem_rdata;
            end
            if (update_pc) begin
                pc <= next_pc;
            end
            if (count_retire) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end

    // Request is masked during reset so a reset cycle never starts a fetch
    assign imem_req    = rst_n && (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign pc_plus4    = pc + 32'd4;

`ifdef IFU_ALIGN_CHECK_EN
    assign addr_err = (state == ERR);
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// ----------------------------------------------------------------------------
// tb_ifu
// Directed testbench for ifu. Inputs are changed 1 time unit after each
// rising edge and outputs are checked at the same point.
// ----------------------------------------------------------------------------
module tb_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic [1:0]  s;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] retired_cnt;
    logic        addr_err;

    int n_compared;
    int n_failed;

    ifu #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .s           (s),
        .zero        (zero),
        .rs_data     (rs_data),
        .retired_cnt (retired_cnt),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full instruction: ack in the first FETCH cycle, retire in the
    // first HOLD cycle with the given next-PC inputs.
    task automatic applyStimulus(input logic [31:0] word, input logic [1:0] sel,
                                 input logic z, input logic [31:0] rs);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        retire     = 1'b1;
        s          = sel;
        zero       = z;
        rs_data    = rs;
        step();
        retire     = 1'b0;
        s          = 2'b00;
        zero       = 1'b0;
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        retire     = 1'b0;
        s          = 2'b00;
        zero       = 1'b0;
        rs_data    = 32'd0;

        // Reset state
        step();
        step();
        checkOutput("rst_pc",       pc,                 32'h0000_3000);
        checkOutput("rst_instr",    instr,              32'd0);
        checkOutput("rst_valid",    {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_req",      {31'd0, imem_req},  32'd0);
        checkOutput("rst_cnt",      retired_cnt,        32'd0);
        checkOutput("rst_addr_err", {31'd0, addr_err},  32'd0);

        // First fetch, immediate ack
        rst_n = 1'b1;
        #1;
        checkOutput("fetch0_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("fetch0_addr", imem_addr,         32'h0000_3000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        imem_ack = 1'b0;
        checkOutput("hold0_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("hold0_instr", instr,               32'h2008_0005);
        checkOutput("hold0_req",   {31'd0, imem_req},   32'd0);
        checkOutput("hold0_p4",    pc_plus4,            32'h0000_3004);
        retire = 1'b1;
        s      = 2'b00;
        step();
        retire = 1'b0;
        checkOutput("seq_pc",    pc,                   32'h0000_3004);
        checkOutput("seq_cnt",   retired_cnt,          32'd1);
        checkOutput("seq_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("seq_req",   {31'd0, imem_req},    32'd1);

        // beq backwards, taken and not taken, from 0x3010
        applyStimulus(32'h0000_0000, 2'b11, 1'b0, 32'h0000_3010);
        checkOutput("jr_3010", pc, 32'h0000_3010);
        applyStimulus(32'h1000_FFFC, 2'b01, 1'b1, 32'd0);
        checkOutput("beq_taken", pc, 32'h0000_3004);
        applyStimulus(32'h0000_0000, 2'b11, 1'b0, 32'h0000_3010);
        applyStimulus(32'h1000_FFFC, 2'b01, 1'b0, 32'd0);
        checkOutput("beq_not_taken", pc, 32'h0000_3014);

        // j from 0x3000, then jr
        applyStimulus(32'h0000_0000, 2'b11, 1'b0, 32'h0000_3000);
        applyStimulus(32'h0800_0C10, 2'b10, 1'b0, 32'd0);
        checkOutput("j_pc",  pc,       32'h0000_3040);
        checkOutput("j_p4",  pc_plus4, 32'h0000_3044);
        applyStimulus(32'h0000_0000, 2'b11, 1'b0, 32'h0000_3100);
        checkOutput("jr_pc",  pc,          32'h0000_3100);
        checkOutput("jr_cnt", retired_cnt, 32'd8);

        // Wait states: three cycles without ack, retire pulsed meanwhile
        for (int i = 0; i < 4; i++) begin
            checkOutput("ws_req",   {31'd0, imem_req},    32'd1);
            checkOutput("ws_addr",  imem_addr,            32'h0000_3100);
            checkOutput("ws_valid", {31'd0, instr_valid}, 32'd0);
            if (i < 3) begin
                retire  = (i == 1);
                s       = 2'b11;
                rs_data = 32'h0000_4000;
                step();
                retire  = 1'b0;
                s       = 2'b00;
            end
        end
        checkOutput("ws_pc_kept",  pc,          32'h0000_3100);
        checkOutput("ws_cnt_kept", retired_cnt, 32'd8);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0000;
        step();
        imem_ack = 1'b0;
        checkOutput("ws_hold_valid", {31'd0, instr_valid}, 32'd1);

        // Reset while holding an instruction at 0x3020, with a stray ack
        retire  = 1'b1;
        s       = 2'b11;
        rs_data = 32'h0000_3020;
        step();
        retire   = 1'b0;
        s        = 2'b00;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checkOutput("pre_rst_pc",    pc,                   32'h0000_3020);
        checkOutput("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checkOutput("mid_rst_pc",    pc,                   32'h0000_3000);
        checkOutput("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("mid_rst_cnt",   retired_cnt,          32'd0);
        checkOutput("mid_rst_req",   {31'd0, imem_req},    32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_req",  {31'd0, imem_req}, 32'd1);
        checkOutput("post_rst_addr", imem_addr,         32'h0000_3000);

        // Misaligned jr target
        applyStimulus(32'h0000_0000, 2'b11, 1'b0, 32'h0000_3002);
        step();
`ifdef IFU_ALIGN_CHECK_EN
        checkOutput("mis_pc",       pc,                   32'h0000_3000);
        checkOutput("mis_addr_err", {31'd0, addr_err},    32'd1);
        checkOutput("mis_req",      {31'd0, imem_req},    32'd0);
        checkOutput("mis_valid",    {31'd0, instr_valid}, 32'd0);
        checkOutput("mis_cnt",      retired_cnt,          32'd1);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checkOutput("err_sticky",   {31'd0, addr_err}, 32'd1);
        checkOutput("err_pc",       pc,                32'h0000_3000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("err_clr",      {31'd0, addr_err}, 32'd0);
        checkOutput("err_clr_req",  {31'd0, imem_req}, 32'd1);
`else
        checkOutput("mis_pc",       pc,                32'h0000_3002);
        checkOutput("mis_addr_err", {31'd0, addr_err}, 32'd0);
        checkOutput("mis_req",      {31'd0, imem_req}, 32'd1);
        checkOutput("mis_cnt",      retired_cnt,       32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
